// File: rtl/rd_port_scheduler_pkg.sv
// Shared definitions for the read-port scheduler and the engines that build its metadata.
// Metadata layout: requester id in the MSBs, requester tag in the remaining LSBs.
package rd_port_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  // Tag width left over once the requester id has taken its MSBs.
  function automatic int mdata_tagw(input int mdata, input int nreq);
    return mdata - $clog2(nreq);
  endfunction

  localparam int DEF_MDATA = 14;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_IDW   = $clog2(DEF_NREQ);
  localparam int DEF_TAGW  = DEF_MDATA - DEF_IDW;

  typedef struct packed {
    logic [DEF_IDW-1:0]  id;
    logic [DEF_TAGW-1:0] tag;
  } mdata_t;

endpackage

// File: rtl/rd_port_scheduler_arb.sv
// Combinational round-robin arbiter: first requester strictly after ptr wins, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  logic [IDW-1:0] idx;
  logic           found;

  // NREQ is a power of two, so ptr + k wraps naturally; k == NREQ revisits ptr last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ptr + IDW'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rd_port_scheduler.sv
// Shares one read request/response port among NREQ requesters: round-robin issue (1 cycle),
// id-based response routing (1 cycle), outstanding-read limit, drain control and stray-response flag.
module rd_port_scheduler
  import rd_port_scheduler_pkg::*;
#(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int NREQ        = 4,
  parameter int MAX_OUT     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NREQ-1:0]                       req_valid,
  input  logic [NREQ*ADDR_LMT-1:0]              req_addr,
  input  logic [NREQ*mdata_tagw(MDATA,NREQ)-1:0] req_tag,
  output logic [NREQ-1:0]                       req_ready,
  output logic [ADDR_LMT-1:0]                   rd_req_addr,
  output logic [MDATA-1:0]                      rd_req_mdata,
  output logic                                  rd_req_en,
  input  logic                                  rd_req_almostfull,
  input  logic                                  rd_rsp_valid,
  input  logic [MDATA-1:0]                      rd_rsp_mdata,
  input  logic [CACHE_WIDTH-1:0]                rd_rsp_data,
  output logic [NREQ-1:0]                       rsp_valid,
  output logic [mdata_tagw(MDATA,NREQ)-1:0]     rsp_tag,
  output logic [CACHE_WIDTH-1:0]                rsp_data,
  input  logic                                  drain,
  output logic                                  idle,
  output logic [$clog2(MAX_OUT):0]              outstanding,
  output logic                                  err
);

  localparam int IDW  = $clog2(NREQ);
  localparam int TAGW = mdata_tagw(MDATA, NREQ);
  localparam int CW   = $clog2(MAX_OUT) + 1;

  sched_state_t    state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic            eligible;
  logic            accept;
  logic [IDW-1:0]  gid;
  logic [ADDR_LMT-1:0] sel_addr;
  logic [TAGW-1:0] sel_tag;
  logic [IDW-1:0]  rsp_id;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign eligible = (state != ST_DRAIN) && !drain && !rd_req_almostfull &&
                    (outstanding < CW'(MAX_OUT));
  assign req_ready = eligible ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign rsp_id    = rd_rsp_mdata[MDATA-1 -: IDW];
  assign idle      = ((state == ST_IDLE) || (state == ST_DRAIN)) && (outstanding == '0);

  always_comb begin
    gid      = '0;
    sel_addr = '0;
    sel_tag  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gid      = IDW'(i);
        sel_addr = req_addr[i*ADDR_LMT +: ADDR_LMT];
        sel_tag  = req_tag[i*TAGW +: TAGW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= IDW'(NREQ - 1);
      outstanding  <= '0;
      err          <= 1'b0;
      rd_req_en    <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
    end else begin
      rd_req_en <= accept;
      if (accept) begin
        ptr          <= gid;
        rd_req_addr  <= sel_addr;
        rd_req_mdata <= {gid, sel_tag};
      end
      // A response with nothing outstanding is a protocol error; the counter never underflows.
      if (accept && !rd_rsp_valid) begin
        outstanding <= outstanding + CW'(1);
      end else if (!accept && rd_rsp_valid) begin
        if (outstanding == '0) err <= 1'b1;
        else                   outstanding <= outstanding - CW'(1);
      end
      case (state)
        ST_IDLE:  if (|req_valid && !drain) state <= ST_RUN;
        ST_RUN:   if (drain) state <= ST_DRAIN;
        ST_DRAIN: if ((outstanding == '0) && !drain) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_tag   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (rd_rsp_valid) begin
        rsp_valid[rsp_id] <= 1'b1;
        rsp_tag           <= rd_rsp_mdata[TAGW-1:0];
        rsp_data          <= rd_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_rd_port_scheduler.sv
// Directed bench for rd_port_scheduler with a reference model and issue/response scoreboards.
module tb_rd_port_scheduler;

  logic         clk;
  logic         rst;
  logic [3:0]   rv;
  logic [19:0]  ra [4];
  logic [11:0]  rt [4];
  logic [3:0]   req_ready;
  logic [19:0]  rd_req_addr;
  logic [13:0]  rd_req_mdata;
  logic         rd_req_en;
  logic         af;
  logic         rsp_in_vld;
  logic [13:0]  rsp_in_md;
  logic [511:0] rsp_in_dat;
  logic [3:0]   rsp_valid;
  logic [11:0]  rsp_tag;
  logic [511:0] rsp_data;
  logic         drain;
  logic         idle;
  logic [4:0]   outstanding;
  logic         err;

  typedef struct { logic [19:0] addr; logic [13:0] md; } iss_t;
  typedef struct { logic [3:0] oh; logic [11:0] tag; logic [511:0] data; } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int m_state, m_ptr, m_out;
  logic m_err;

  rd_port_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (rv),
    .req_addr          ({ra[3], ra[2], ra[1], ra[0]}),
    .req_tag           ({rt[3], rt[2], rt[1], rt[0]}),
    .req_ready         (req_ready),
    .rd_req_addr       (rd_req_addr),
    .rd_req_mdata      (rd_req_mdata),
    .rd_req_en         (rd_req_en),
    .rd_req_almostfull (af),
    .rd_rsp_valid      (rsp_in_vld),
    .rd_rsp_mdata      (rsp_in_md),
    .rd_rsp_data       (rsp_in_dat),
    .rsp_valid         (rsp_valid),
    .rsp_tag           (rsp_tag),
    .rsp_data          (rsp_data),
    .drain             (drain),
    .idle              (idle),
    .outstanding       (outstanding),
    .err               (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    rv = '0;
    rsp_in_vld = 1'b0;
    #1;
    check("rst_en", rd_req_en, 1'b0);
    check("rst_addr", rd_req_addr, 20'h0);
    check("rst_mdata", rd_req_mdata, 14'h0);
    check("rst_rsp_valid", rsp_valid, 4'h0);
    check("rst_rsp_tag", rsp_tag, 12'h0);
    check("rst_rsp_data", rsp_data, 512'h0);
    check("rst_outstanding", outstanding, 5'd0);
    check("rst_err", err, 1'b0);
    check("rst_idle", idle, 1'b1);
    m_state = 0; m_ptr = 3; m_out = 0; m_err = 1'b0;
    iss_q.delete();
    rsp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock: predict ready/issue/response before the edge, compare outputs after it.
  task automatic cycle();
    logic [3:0] er;
    int g, n_state, n_out;
    logic n_err;
    iss_t ie;
    rsp_t re;
    #1;
    er = '0;
    g = -1;
    if (m_state != 2 && !drain && !af && m_out < 16)
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (g < 0 && rv[idx]) g = idx;
      end
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", req_ready, er);
    if (g >= 0) begin
      ie.addr = ra[g];
      ie.md = {g[1:0], rt[g]};
      iss_q.push_back(ie);
    end
    if (rsp_in_vld) begin
      re.oh = 4'b0001 << rsp_in_md[13:12];
      re.tag = rsp_in_md[11:0];
      re.data = rsp_in_dat;
      rsp_q.push_back(re);
    end
    n_out = m_out;
    n_err = m_err;
    if (g >= 0 && !rsp_in_vld) n_out = m_out + 1;
    else if (g < 0 && rsp_in_vld) begin
      if (m_out == 0) n_err = 1'b1;
      else n_out = m_out - 1;
    end
    n_state = m_state;
    if (m_state == 0 && |rv && !drain) n_state = 1;
    else if (m_state == 1 && drain) n_state = 2;
    else if (m_state == 2 && m_out == 0 && !drain) n_state = 0;
    @(posedge clk); #1;
    m_state = n_state;
    m_out = n_out;
    m_err = n_err;
    if (g >= 0) m_ptr = g;
    check("rd_req_en", rd_req_en, g >= 0);
    if (rd_req_en) en_cnt++;
    if (g >= 0 && iss_q.size() > 0) begin
      ie = iss_q.pop_front();
      check("rd_req_addr", rd_req_addr, ie.addr);
      check("rd_req_mdata", rd_req_mdata, ie.md);
    end
    if (rsp_q.size() > 0) begin
      re = rsp_q.pop_front();
      check("rsp_valid", rsp_valid, re.oh);
      check("rsp_tag", rsp_tag, re.tag);
      check("rsp_data", rsp_data, re.data);
    end else begin
      check("rsp_valid_idle", rsp_valid, 4'h0);
    end
    check("outstanding", outstanding, m_out[4:0]);
    check("err", err, m_err);
    check("idle", idle, (m_state != 1) && (m_out == 0));
    // Accepted requesters present a fresh request next.
    if (g >= 0) begin
      ra[g] = ra[g] + 20'h100;
      rt[g] = rt[g] + 12'h1;
    end
    rsp_in_vld = 1'b0;
  endtask

  task automatic respond(input logic [13:0] md);
    rsp_in_vld = 1'b1;
    rsp_in_md = md;
    rsp_in_dat = {16{$urandom()}};
    cycle();
  endtask

  int ids[5] = '{0, 1, 2, 3, 0};
  int e0;

  initial begin
    rst = 1'b1; rv = '0; af = 1'b0; drain = 1'b0;
    rsp_in_vld = 1'b0; rsp_in_md = '0; rsp_in_dat = '0;
    for (int i = 0; i < 4; i++) begin ra[i] = 20'h0; rt[i] = 12'h0; end
    @(posedge clk); #1;
    reset_dut();

    // Single request from requester 0.
    rv = 4'b0001; ra[0] = 20'h10; rt[0] = 12'h5;
    cycle();
    rv = '0;
    check("single_en", rd_req_en, 1'b1);
    check("single_addr", rd_req_addr, 20'h10);
    check("single_mdata", rd_req_mdata, 14'h0005);
    check("single_out", outstanding, 5'd1);

    // All requesters valid: fresh pointer rotates 0,1,2,3,0.
    reset_dut();
    for (int i = 0; i < 4; i++) begin ra[i] = 20'h1000 * (i + 1); rt[i] = 12'h100 * i; end
    rv = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_id", rd_req_mdata[13:12], ids[i]);
    end

    // Fill to the limit, then one response frees exactly one slot.
    for (int i = 0; i < 11; i++) cycle();
    check("full_out", outstanding, 5'd16);
    cycle();
    check("full_no_en", rd_req_en, 1'b0);
    respond(14'h1ABC);
    e0 = en_cnt;
    for (int i = 0; i < 3; i++) cycle();
    check("one_more_grant", en_cnt - e0, 1);
    check("refull_out", outstanding, 5'd16);

    // Reset mid-flight, then a late response is a stray.
    reset_dut();
    respond(14'h1ABC);
    check("late_err", err, 1'b1);
    check("late_out", outstanding, 5'd0);
    check("late_route", rsp_valid, 4'b0010);

    // Almost-full backpressure.
    reset_dut();
    rv = 4'b1111; af = 1'b1;
    e0 = en_cnt;
    for (int i = 0; i < 3; i++) cycle();
    af = 1'b0;
    check("af_hold", en_cnt - e0, 0);
    cycle();
    cycle();
    check("af_resume", en_cnt - e0, 2);

    // Accept and response together at outstanding 3.
    reset_dut();
    rv = 4'b1111;
    for (int i = 0; i < 3; i++) cycle();
    respond(14'h3007);
    rv = '0;
    check("same_out", outstanding, 5'd3);
    check("same_onehot", rsp_valid, 4'b1000);
    check("same_tag", rsp_tag, 12'h007);

    // Drain with 2 outstanding.
    respond(14'h0001);
    drain = 1'b1; rv = 4'b1111;
    cycle();
    check("drain_busy", idle, 1'b0);
    respond(14'h0002);
    check("drain_one_left", idle, 1'b0);
    respond(14'h0003);
    check("drain_idle", idle, 1'b1);
    respond(14'h2004);
    check("stray_err", err, 1'b1);
    drain = 1'b0; rv = '0;
    cycle();
    check("back_idle", idle, 1'b1);
    rv = 4'b0001;
    cycle();
    rv = '0;
    check("resume_en", rd_req_en, 1'b1);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rd_port_scheduler.md
RD_PORT_SCHEDULER -- requirements
Module: rd_port_scheduler

Interface
REQ-001 SHALL have parameter ADDR_LMT, default 20, read line-address width.
REQ-002 SHALL have parameter MDATA, default 14, read metadata width.
REQ-003 SHALL have parameter CACHE_WIDTH, default 512, response line width.
REQ-004 SHALL have parameter NREQ, default 4, requester count (power of 2, >=2); IDW = log2(NREQ), TAGW = MDATA-IDW.
REQ-005 SHALL have parameter MAX_OUT, default 16, maximum outstanding reads (power of 2).
REQ-006 SHALL have port clk, in, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port rst, in, 1, asynchronous, active-high reset.
REQ-008 SHALL have ports req_valid in NREQ, req_addr in NREQ*ADDR_LMT, req_tag in NREQ*TAGW, req_ready out NREQ: per-requester read request, packed index-major.
REQ-009 SHALL have ports rd_req_addr out ADDR_LMT, rd_req_mdata out MDATA, rd_req_en out 1, rd_req_almostfull in 1: shared read request port.
REQ-010 SHALL have ports rd_rsp_valid in 1, rd_rsp_mdata in MDATA, rd_rsp_data in CACHE_WIDTH: shared read response port.
REQ-011 SHALL have ports rsp_valid out NREQ, rsp_tag out TAGW, rsp_data out CACHE_WIDTH: routed responses.
REQ-012 SHALL have ports drain in 1, idle out 1, outstanding out log2(MAX_OUT)+1, err out 1.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-014 IDLE -> RUN when any req_valid high and drain low; RUN -> DRAIN when drain high; DRAIN -> IDLE when outstanding==0 and drain low; DRAIN holds while drain is high.
REQ-015 Grant eligibility: state IDLE or RUN, drain low, rd_req_almostfull low, outstanding < MAX_OUT.
REQ-016 When eligible, exactly one req_ready bit SHALL be high (combinational): first valid requester strictly after the last-granted index, round-robin, wrapping; reset pointer = NREQ-1, so requester 0 wins first.
REQ-017 Handshake: accept when req_valid[i] && req_ready[i]; next cycle rd_req_en=1, rd_req_addr=req_addr[i], rd_req_mdata={i[IDW-1:0], req_tag[i]} with id in MSBs; 1-cycle latency, at most one issue per cycle.
REQ-018 rd_req_en SHALL be low in every cycle after one with no acceptance; rd_req_addr/mdata hold their last values.
REQ-019 Response: when rd_rsp_valid, next cycle rsp_valid[rd_rsp_mdata[MDATA-1 -: IDW]]=1 (one-hot), rsp_tag=low TAGW bits, rsp_data=rd_rsp_data; registered, 1-cycle latency.
REQ-020 outstanding: +1 on accept, -1 on rd_rsp_valid, unchanged on both in the same cycle; never exceeds MAX_OUT.
REQ-021 Response while outstanding==0 with no same-cycle accept: counter stays 0, err sets sticky until reset; data still routed.
REQ-022 idle SHALL be 1 iff state is IDLE or DRAIN and outstanding==0.
REQ-023 Requests with req_valid held and no ready SHALL keep their address/tag stable (requester obligation); the scheduler SHALL NOT drop or duplicate.

Reset
REQ-024 On rst: state IDLE, pointer NREQ-1, outstanding 0, err 0, rd_req_en 0, rd_req_addr 0, rd_req_mdata 0, rsp_valid 0, rsp_tag 0, rsp_data 0, idle 1.
REQ-025 Reset mid-operation SHALL discard in-flight bookkeeping; late responses after reset follow REQ-021.

Structure
REQ-026 Shared package SHALL hold the FSM state enum and the mdata field split (id MSBs, tag LSBs) for reuse by requesting engines.
REQ-027 The round-robin arbiter SHALL be one sub-module, rr_arbiter (req vector, pointer in, one-hot grant out, combinational).

Verification
REQ-028 Reset, then req_valid=4'b0001, addr 0x10, tag 5 -> next cycle rd_req_en=1, addr 0x10, mdata=0x0005; outstanding=1.
REQ-029 All four valid continuously -> grants 0,1,2,3,0 on consecutive cycles; mdata id field matches.
REQ-030 16 issues, no responses -> req_ready all low; one response -> exactly one further grant next cycle.
REQ-031 rd_req_almostfull=1 for 3 cycles with valids pending -> no rd_req_en in those cycles +1; resumes afterward.
REQ-032 Accept and rd_rsp_valid in the same cycle at outstanding=3 -> stays 3; rsp mdata 0x3007 -> rsp_valid=4'b1000, rsp_tag=7.
REQ-033 drain=1 with 2 outstanding -> no grants, idle=0 until both responses, then idle=1; stray response at 0 -> err=1.
